ball_motion_controller: RTL and testbench

- Sequential stage directly upstream of the ball direction-change stage.
- Divides the system clock into a ball move tick and steps the ball position one pixel per tick, according to the latched direction code (1..10).
- Outputs ball_coord_horizontal/ball_coord_vertical and the applied direction, and takes new_direction/stand_out back from the direction-change stage.
- Holds the ball at centre for a serve delay, then moves until a stand is signalled.

---
 rtl/ball_motion_controller_if.sv | 21 ++
 rtl/ball_motion_controller.sv | 125 ++++++++++++
 tb/tb_ball_motion_controller.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ball_motion_controller_if.sv
// Link between the ball motion controller and the downstream direction-change stage.
// master = motion controller, slave = direction-change stage.
interface ball_motion_controller_if;
  logic        stand;
  logic [3:0]  new_direction;
  logic [15:0] ball_coord_horizontal;
  logic [15:0] ball_coord_vertical;
  logic [3:0]  direction;
  logic        move_tick;
  logic        moving;

  modport master (
    input  stand, new_direction,
    output ball_coord_horizontal, ball_coord_vertical, direction, move_tick, moving
  );

  modport slave (
    output stand, new_direction,
    input  ball_coord_horizontal, ball_coord_vertical, direction, move_tick, moving
  );
endinterface

// File: rtl/ball_motion_controller.sv
// Ball motion controller: divides clk into move ticks, serves from centre, then steps
// the ball one pixel per tick along the latched direction until a stand freezes it.
module ball_motion_controller #(
  parameter int unsigned CLK_DIV     = 250000,
  parameter int unsigned SERVE_TICKS = 100,
  parameter int unsigned START_H     = 462,
  parameter int unsigned START_V     = 302,
  parameter int unsigned START_DIR   = 3
) (
  input logic                     clk,
  input logic                     reset_to_start,
  ball_motion_controller_if.master bus
);

  localparam int unsigned DIV_W   = $clog2(CLK_DIV);
  localparam int unsigned SERVE_W = (SERVE_TICKS > 1) ? $clog2(SERVE_TICKS) : 1;

  localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0]   DIV_PRE    = DIV_W'(CLK_DIV - 2);
  localparam logic [SERVE_W-1:0] SERVE_LAST = SERVE_W'(SERVE_TICKS - 1);
  localparam logic [15:0]        X_START    = 16'(START_H);
  localparam logic [15:0]        Y_START    = 16'(START_V);
  localparam logic [3:0]         DIR_START  = 4'(START_DIR);

  typedef enum logic [1:0] {SERVE, MOVE, STOP} state_t;

  state_t             state_q, state_d;
  logic [DIV_W-1:0]   div_cnt;
  logic [SERVE_W-1:0] serve_cnt;
  logic               tick_q;
  logic               moving_q;
  logic               phase_q;
  logic [3:0]         dir_q;
  logic [15:0]        x_q, y_q;
  logic [15:0]        x_step, y_step;
  logic               x_inc, x_dec, y_up, y_down;

  assign bus.ball_coord_horizontal = x_q;
  assign bus.ball_coord_vertical   = y_q;
  assign bus.direction             = dir_q;
  assign bus.move_tick             = tick_q;
  assign bus.moving                = moving_q;

  // NOTE: every register below uses <= so all flops sample pre-edge values together.
  always_ff @(posedge clk or posedge reset_to_start) begin
    if (reset_to_start) state_q <= SERVE;
    else                state_q <= state_d;
  end

  // NOTE: defaults come first so no path through the block can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SERVE:   if (tick_q && serve_cnt == SERVE_LAST) state_d = MOVE;
      MOVE:    if (bus.stand) state_d = STOP;
      default: state_d = state_q;
    endcase
  end

  // Direction code to step: slow vertical codes move only on odd-phase ticks.
  always_comb begin
    x_inc  = 1'b0;
    x_dec  = 1'b0;
    y_up   = 1'b0;
    y_down = 1'b0;
    case (dir_q)
      4'd1:  begin x_inc = 1'b1; y_up   = 1'b1;    end
      4'd2:  begin x_inc = 1'b1; y_up   = phase_q; end
      4'd3:  begin x_inc = 1'b1;                   end
      4'd4:  begin x_inc = 1'b1; y_down = phase_q; end
      4'd5:  begin x_inc = 1'b1; y_down = 1'b1;    end
      4'd6:  begin x_dec = 1'b1; y_down = 1'b1;    end
      4'd7:  begin x_dec = 1'b1; y_down = phase_q; end
      4'd8:  begin x_dec = 1'b1;                   end
      4'd9:  begin x_dec = 1'b1; y_up   = phase_q; end
      4'd10: begin x_dec = 1'b1; y_up   = 1'b1;    end
      default: ;
    endcase

    // Saturate at both ends so the ball never wraps across the screen.
    x_step = x_q;
    y_step = y_q;
    if (x_inc && x_q != 16'hFFFF)      x_step = x_q + 16'd1;
    else if (x_dec && x_q != 16'h0000) x_step = x_q - 16'd1;
    if (y_down && y_q != 16'hFFFF)     y_step = y_q + 16'd1;
    else if (y_up && y_q != 16'h0000)  y_step = y_q - 16'd1;
  end

  always_ff @(posedge clk or posedge reset_to_start) begin
    if (reset_to_start) begin
      div_cnt   <= '0;
      tick_q    <= 1'b0;
      serve_cnt <= '0;
      moving_q  <= 1'b0;
      phase_q   <= 1'b0;
      dir_q     <= DIR_START;
      x_q       <= X_START;
      y_q       <= Y_START;
    end else begin
      div_cnt  <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
      // Registered strobe is high exactly while div_cnt sits at DIV_LAST.
      tick_q   <= (div_cnt == DIV_PRE);
      moving_q <= (state_d == MOVE);

      case (state_q)
        SERVE: begin
          if (tick_q) begin
            if (serve_cnt == SERVE_LAST) phase_q <= 1'b0;
            else                         serve_cnt <= serve_cnt + SERVE_W'(1);
          end
        end
        MOVE: begin
          if (!bus.stand && tick_q) begin
            dir_q   <= bus.new_direction;
            x_q     <= x_step;
            y_q     <= y_step;
            phase_q <= ~phase_q;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ball_motion_controller.sv
// Self-checking bench for ball_motion_controller: tick-count reference model checked
// every clock, a direction vector table, random steering and hand-written corner cases.
module tb_ball_motion_controller;

  localparam int CLK_DIV     = 4;
  localparam int SERVE_TICKS = 2;
  localparam int START_H     = 462;
  localparam int START_V     = 302;
  localparam int START_DIR   = 3;

  localparam int M_SERVE = 0;
  localparam int M_MOVE  = 1;
  localparam int M_STOP  = 2;

  logic clk = 1'b0;
  logic reset_to_start = 1'b1;

  ball_motion_controller_if bus ();

  ball_motion_controller #(
    .CLK_DIV     (CLK_DIV),
    .SERVE_TICKS (SERVE_TICKS),
    .START_H     (START_H),
    .START_V     (START_V),
    .START_DIR   (START_DIR)
  ) dut (
    .clk            (clk),
    .reset_to_start (reset_to_start),
    .bus            (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: time is counted in clocks since reset; tick k lands on clock k*CLK_DIV.
  int m_n     = 0;
  int m_mt    = 0;
  int m_x     = START_H;
  int m_y     = START_V;
  int m_dir   = START_DIR;
  int m_mode  = M_SERVE;
  int m_moves = 0;

  function automatic int clamp16(input int v);
    return (v < 0) ? 0 : (v > 65535) ? 65535 : v;
  endfunction

  function automatic int dx_of(input int d);
    return (d >= 1 && d <= 5) ? 1 : (d >= 6 && d <= 10) ? -1 : 0;
  endfunction

  // Signed vertical rate: magnitude 2 = every tick, 1 = odd phase only; negative is up.
  function automatic int dy_of(input int d, input int ph);
    int v;
    v = (d >= 1 && d <= 5) ? d - 3 : (d >= 6 && d <= 10) ? 8 - d : 0;
    if (v == 2 || v == -2)     return v / 2;
    if (v != 0 && ph == 1)     return v;
    return 0;
  endfunction

  always @(posedge clk or posedge reset_to_start) begin
    if (reset_to_start) begin
      m_n <= 0; m_mt <= 0; m_x <= START_H; m_y <= START_V;
      m_dir <= START_DIR; m_mode <= M_SERVE; m_moves <= 0;
    end else begin
      m_n  <= m_n + 1;
      m_mt <= (((m_n + 2) % CLK_DIV) == 0) ? 1 : 0;
      if (m_mode == M_MOVE && bus.stand) begin
        m_mode <= M_STOP;
      end else if (((m_n + 1) % CLK_DIV) == 0) begin
        if (m_mode == M_SERVE && (m_n + 1) / CLK_DIV == SERVE_TICKS) begin
          m_mode <= M_MOVE;
        end else if (m_mode == M_MOVE) begin
          m_x     <= clamp16(m_x + dx_of(m_dir));
          m_y     <= clamp16(m_y + dy_of(m_dir, m_moves % 2));
          m_dir   <= int'(bus.new_direction);
          m_moves <= m_moves + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("x",         int'(bus.ball_coord_horizontal), m_x);
    check("y",         int'(bus.ball_coord_vertical),   m_y);
    check("dir",       int'(bus.direction),             m_dir);
    check("move_tick", int'(bus.move_tick),             m_mt);
    check("moving",    int'(bus.moving),                (m_mode == M_MOVE) ? 1 : 0);
  end

  // Park on the negedge just before the next tick edge.
  task automatic align();
    int guard = 0;
    @(negedge clk);
    while (m_mt == 0 && guard < CLK_DIV + 2) begin
      @(negedge clk);
      guard++;
    end
    if (m_mt == 0) begin
      checks++;
      errors++;
      $display("FAIL tick_align actual=0 expected=1 at %0t", $time);
    end
  endtask

  // Return on the negedge right after the next tick edge.
  task automatic tick_edge();
    align();
    @(negedge clk);
  endtask

  task automatic check_pos(input string name, input int x, input int y);
    check({name, "_x"}, int'(bus.ball_coord_horizontal), x);
    check({name, "_y"}, int'(bus.ball_coord_vertical),   y);
  endtask

  typedef struct {
    logic [3:0] dir;
    int         dx2;
    int         dy2;
  } dir_vec_t;

  dir_vec_t vecs [14];

  initial begin
    int bx, by;

    vecs[0]  = '{4'd1,   2, -2};
    vecs[1]  = '{4'd2,   2, -1};
    vecs[2]  = '{4'd3,   2,  0};
    vecs[3]  = '{4'd4,   2,  1};
    vecs[4]  = '{4'd5,   2,  2};
    vecs[5]  = '{4'd6,  -2,  2};
    vecs[6]  = '{4'd7,  -2,  1};
    vecs[7]  = '{4'd8,  -2,  0};
    vecs[8]  = '{4'd9,  -2, -1};
    vecs[9]  = '{4'd10, -2, -2};
    vecs[10] = '{4'd0,   0,  0};
    vecs[11] = '{4'd11,  0,  0};
    vecs[12] = '{4'd12,  0,  0};
    vecs[13] = '{4'd15,  0,  0};

    bus.stand         = 1'b0;
    bus.new_direction = 4'd3;

    // Reset values.
    repeat (2) @(negedge clk);
    check_pos("rst", START_H, START_V);
    check("rst_dir",    int'(bus.direction), START_DIR);
    check("rst_moving", int'(bus.moving),    0);
    check("rst_tick",   int'(bus.move_tick), 0);
    reset_to_start = 1'b0;

    // Serve delay, then first step with START_DIR.
    tick_edge();
    check_pos("serve1", 462, 302);
    check("serve1_moving", int'(bus.moving), 0);
    tick_edge();
    check_pos("serve2", 462, 302);
    check("serve2_moving", int'(bus.moving), 1);
    tick_edge();
    check_pos("step1", 463, 302);
    check("step1_dir", int'(bus.direction), 3);

    // Direction 1 latched, then four diagonal up-right steps.
    bus.new_direction = 4'd1;
    tick_edge();
    check_pos("latch1", 464, 302);
    check("latch1_dir", int'(bus.direction), 1);
    repeat (4) tick_edge();
    check_pos("diag4", 468, 298);

    // Direction table: latch a code, then measure the displacement over two ticks.
    for (int i = 0; i < 14; i++) begin
      bus.new_direction = vecs[i].dir;
      tick_edge();
      check("tbl_dir", int'(bus.direction), int'(vecs[i].dir));
      bx = m_x;
      by = m_y;
      tick_edge();
      tick_edge();
      check("tbl_dx", int'(bus.ball_coord_horizontal) - bx, vecs[i].dx2);
      check("tbl_dy", int'(bus.ball_coord_vertical) - by,   vecs[i].dy2);
    end

    // Random steering, mostly legal codes with occasional illegal ones.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) bus.new_direction = 4'($urandom_range(11, 16) % 16);
      else                           bus.new_direction = 4'($urandom_range(1, 10));
      tick_edge();
    end

    // Asynchronous reset between clock edges mid-MOVE.
    bus.new_direction = 4'd3;
    @(negedge clk);
    #3 reset_to_start = 1'b1;
    #1;
    check_pos("async_rst", START_H, START_V);
    check("async_rst_dir",    int'(bus.direction), START_DIR);
    check("async_rst_moving", int'(bus.moving),    0);
    repeat (2) @(negedge clk);
    reset_to_start = 1'b0;
    tick_edge();
    check("reserve1_moving", int'(bus.moving), 0);
    tick_edge();
    check("reserve2_moving", int'(bus.moving), 1);
    check_pos("reserve2", 462, 302);
    tick_edge();
    check_pos("restep1", 463, 302);

    // Left edge saturation, then top edge saturation.
    bus.new_direction = 4'd8;
    repeat (701) tick_edge();
    check_pos("sat_left", 0, 302);
    check("sat_left_dir", int'(bus.direction), 8);
    bus.new_direction = 4'd10;
    repeat (400) tick_edge();
    check_pos("sat_corner", 0, 0);

    // Leave the corner, then stand on a tick clock: no step, STOP is sticky.
    bus.new_direction = 4'd5;
    tick_edge();
    check_pos("corner_hold", 0, 0);
    tick_edge();
    check_pos("corner_leave", 1, 1);
    align();
    bus.stand = 1'b1;
    @(negedge clk);
    check_pos("stand", 1, 1);
    check("stand_moving", int'(bus.moving), 0);
    bus.stand = 1'b0;
    repeat (10 * CLK_DIV) @(negedge clk);
    check_pos("stop_hold", 1, 1);
    check("stop_moving", int'(bus.moving), 0);
    check("stop_dir",    int'(bus.direction), 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
